// File: rtl/pipe_delay_line_pkg.sv
// Shared constants and helpers for the PipeGen delay line.
// Width derivations (TapW, CntW) use the clog2 helper below.
package pipe_delay_line_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;

  // ceil(log2(v)); used for constant parameter derivation only.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_delay_line_stage.sv
// One delay-line stage: data register plus valid bit.
// load captures {v_in, d_in}; clr drops only the valid bit and keeps the data.
module pipe_stage
  import pipe_delay_line_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clr,
  input  logic [DataWidth-1:0] d_in,
  input  logic                 v_in,
  output logic [DataWidth-1:0] d_out,
  output logic                 v_out,
  output logic                 v_nxt
);

  logic [DataWidth-1:0] data_q, data_d;
  logic                 vld_q,  vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load) begin
      data_d = d_in;
      vld_d  = v_in;
    end else if (clr) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign d_out = data_q;
  assign v_out = vld_q;
  assign v_nxt = vld_d;

endmodule

// File: rtl/pipe_delay_line.sv
// Stall-aware, valid-tracked delay line with a runtime output tap.
// Holds the stage chain, the tap mux, the registered occupancy count and the packed views.
module pipe_delay_line
  import pipe_delay_line_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_W,
  parameter int Depth     = DEF_DEPTH,
  parameter int TapW      = clog2(Depth),
  parameter int CntW      = clog2(Depth + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       din_valid,
  input  logic [DataWidth-1:0]       din,
  input  logic [TapW-1:0]            tap,
  output logic [DataWidth-1:0]       dout,
  output logic                       dout_valid,
  output logic [DataWidth*Depth-1:0] wdout,
  output logic [Depth-1:0]           wvalid,
  output logic [CntW-1:0]            count,
  output logic                       busy
);

  localparam logic [TapW:0] LAST = (TapW + 1)'(Depth - 1);

  logic [Depth-1:0][DataWidth-1:0] stage_data;
  logic [Depth-1:0][DataWidth-1:0] in_data;
  logic [Depth-1:0]                in_vld;
  logic [Depth-1:0]                vld_next;
  logic [Depth-1:0]                load;
  logic [Depth-1:0]                clr;

  // Stage 0 still loads during a flush when not stalled (flush-and-load);
  // every other stage just loses its valid bit.
  for (genvar i = 0; i < Depth; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign in_data[i] = din;
      assign in_vld[i]  = din_valid;
      assign load[i]    = ~stall;
    end else begin : g_body
      assign in_data[i] = stage_data[i-1];
      assign in_vld[i]  = wvalid[i-1];
      assign load[i]    = ~stall & ~flush;
    end
    assign clr[i] = flush & ~load[i];

    pipe_stage #(.DataWidth(DataWidth)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .clr   (clr[i]),
      .d_in  (in_data[i]),
      .v_in  (in_vld[i]),
      .d_out (stage_data[i]),
      .v_out (wvalid[i]),
      .v_nxt (vld_next[i])
    );
  end

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < Depth; i++) count_d = count_d + CntW'(vld_next[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Out-of-range taps (non-power-of-2 Depth) clamp to the last stage.
  logic [TapW-1:0] sel;
  always_comb begin
    sel = tap;
    if ({1'b0, tap} > LAST) sel = LAST[TapW-1:0];
  end

  assign dout       = stage_data[sel];
  assign dout_valid = wvalid[sel];
  assign wdout      = stage_data;
  assign count      = count_q;
  assign busy       = |wvalid;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed + random bench for pipe_delay_line (Depth=8 and Depth=5 instances)
// against a stage-array reference model.
module tb_pipe_delay_line;

  logic        clk = 1'b0;
  logic        rst, stall, flush, din_valid;
  logic [31:0] din;
  logic [2:0]  tap;

  logic [31:0]  dout_a, dout_b;
  logic         dv_a, dv_b;
  logic [255:0] wdout_a;
  logic [159:0] wdout_b;
  logic [7:0]   wvalid_a;
  logic [4:0]   wvalid_b;
  logic [3:0]   count_a;
  logic [2:0]   count_b;
  logic         busy_a, busy_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_delay_line #(.DataWidth(32), .Depth(8)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .din_valid(din_valid), .din(din),
    .tap(tap), .dout(dout_a), .dout_valid(dv_a), .wdout(wdout_a), .wvalid(wvalid_a),
    .count(count_a), .busy(busy_a));

  pipe_delay_line #(.DataWidth(32), .Depth(5)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .din_valid(din_valid), .din(din),
    .tap(tap), .dout(dout_b), .dout_valid(dv_b), .wdout(wdout_b), .wvalid(wvalid_b),
    .count(count_b), .busy(busy_b));

  // Reference model: one entry per stage, index 0 newest.
  logic [31:0] ma [8];
  logic        mva[8];
  logic [31:0] mb [5];
  logic        mvb[5];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, s, f, dv, input logic [31:0] d);
    if (r) begin
      for (int i = 0; i < 8; i++) begin ma[i] = '0; mva[i] = 1'b0; end
      for (int i = 0; i < 5; i++) begin mb[i] = '0; mvb[i] = 1'b0; end
    end else if (f) begin
      for (int i = 0; i < 8; i++) mva[i] = 1'b0;
      for (int i = 0; i < 5; i++) mvb[i] = 1'b0;
      if (!s) begin
        ma[0] = d; mva[0] = dv;
        mb[0] = d; mvb[0] = dv;
      end
    end else if (!s) begin
      for (int i = 7; i > 0; i--) begin ma[i] = ma[i-1]; mva[i] = mva[i-1]; end
      for (int i = 4; i > 0; i--) begin mb[i] = mb[i-1]; mvb[i] = mvb[i-1]; end
      ma[0] = d; mva[0] = dv;
      mb[0] = d; mvb[0] = dv;
    end
  endtask

  task automatic check_all();
    int ta, tb, ca, cb;
    logic [255:0] ewa, ewb;
    logic [7:0] eva;
    logic [4:0] evb;
    ta = int'(tap);
    tb = (ta >= 5) ? 4 : ta;
    ca = 0; cb = 0; ewa = '0; ewb = '0; eva = '0; evb = '0;
    for (int i = 0; i < 8; i++) begin
      ewa[i*32 +: 32] = ma[i]; eva[i] = mva[i]; ca += int'(mva[i]);
    end
    for (int i = 0; i < 5; i++) begin
      ewb[i*32 +: 32] = mb[i]; evb[i] = mvb[i]; cb += int'(mvb[i]);
    end
    chk("a_dout",   256'(dout_a),   256'(ma[ta]));
    chk("a_dvalid", 256'(dv_a),     256'(mva[ta]));
    chk("a_wvalid", 256'(wvalid_a), 256'(eva));
    chk("a_count",  256'(count_a),  256'(ca));
    chk("a_busy",   256'(busy_a),   256'(ca != 0));
    chk("a_wdout",  wdout_a,        ewa);
    chk("b_dout",   256'(dout_b),   256'(mb[tb]));
    chk("b_dvalid", 256'(dv_b),     256'(mvb[tb]));
    chk("b_wvalid", 256'(wvalid_b), 256'(evb));
    chk("b_count",  256'(count_b),  256'(cb));
    chk("b_wdout",  256'(wdout_b),  ewb);
  endtask

  task automatic step(input logic r, s, f, dv, input logic [31:0] d);
    rst = r; stall = s; flush = f; din_valid = dv; din = d;
    @(posedge clk);
    model_edge(r, s, f, dv, d);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; din_valid = 1'b0; din = '0; tap = 3'd0;
    for (int i = 0; i < 8; i++) begin ma[i] = 'x; mva[i] = 1'bx; end
    for (int i = 0; i < 5; i++) begin mb[i] = 'x; mvb[i] = 1'bx; end

    // Reset with a valid item presented: nothing gets in.
    step(1, 0, 0, 1, 32'hFF);
    step(1, 0, 0, 1, 32'hFF);
    chk("rst_wvalid", 256'(wvalid_a), 256'(0));
    chk("rst_count",  256'(count_a),  256'(0));
    chk("rst_dout",   256'(dout_a),   256'(0));

    // Streaming at tap=2.
    tap = 3'd2;
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0, 1, 32'(k));
      if (k == 3) begin
        chk("stream_first", 256'(dout_a), 256'(1));
        chk("stream_fv",    256'(dv_a),   256'(1));
      end
    end
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 32'h0);
    chk("stream_drain_cnt", 256'(count_a), 256'(0));

    // Stall: A5 at edge 1, four stalled cycles, visible at tap 3 after edge 8.
    tap = 3'd3;
    step(0, 0, 0, 1, 32'hA5);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 32'hDEAD);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk("stall_early", 256'(dv_a), 256'(0));
    step(0, 0, 0, 0, 32'h0);
    chk("stall_dout", 256'(dout_a), 256'(32'hA5));
    chk("stall_dv",   256'(dv_a),   256'(1));

    // Flush-and-load, then flush while stalled.
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 32'h10 + 32'(k));
    step(0, 0, 1, 1, 32'h77);
    chk("flush_load_wv",  256'(wvalid_a), 256'(8'h01));
    chk("flush_load_cnt", 256'(count_a),  256'(1));
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 32'h20 + 32'(k));
    step(0, 1, 1, 1, 32'h77);
    chk("flush_stall_wv",  256'(wvalid_a), 256'(0));
    chk("flush_stall_cnt", 256'(count_a),  256'(0));

    // Bubble pattern at tap 0, then a tap change with no clock edge.
    tap = 3'd0;
    step(0, 0, 0, 1, 32'h31); chk("bub0", 256'(dv_a), 256'(1));
    step(0, 0, 0, 0, 32'h32); chk("bub1", 256'(dv_a), 256'(0));
    step(0, 0, 0, 1, 32'h33); chk("bub2", 256'(dv_a), 256'(1));
    step(0, 0, 0, 0, 32'h34); chk("bub3", 256'(dv_a), 256'(0));
    for (int k = 0; k < 4; k++) step(0, 0, 0, k[0], 32'h40 + 32'(k));
    tap = 3'd5; #1; check_all();
    tap = 3'd7; #1; check_all();
    chk("clamp_b", 256'(dout_b), 256'(mb[4]));

    // Randomised traffic including mid-stream resets.
    for (int k = 0; k < 400; k++) begin
      tap = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 11) == 0), 1'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
